cgate_micropipeline: RTL and testbench
======================================

Name: cgate_micropipeline

Overview:
Parametrised, synchronously evaluated Muller C-element micropipeline. It is the next generation of the cgates workshop design: a chain of DEPTH clocked C-elements forming a 4-phase bundled-data FIFO, WIDTH bits wide. It sits behind the Tiny Tapeout top-level, with handshake and data pins mapped onto ui_in/uio/uo_out. All state evaluates on one clock, so the pipeline can be observed cycle by cycle.

Parameters:
WIDTH, 8, data bits per token (>=1)
DEPTH, 4, number of C-element stages (>=2); token capacity = ceil(DEPTH/2)

Ports:
clk  in  1  single clock; all state updates on rising edge
rst_n  in  1  asynchronous, active-low reset
in_req  in  1  producer 4-phase request; already synchronised to clk
in_data  in  WIDTH  producer data; must be stable whenever in_req=1 and in_ack=0
in_ack  out  1  producer acknowledge (= c[0])
out_req  out  1  consumer request (= c[DEPTH-1])
out_data  out  WIDTH  consumer data (= d[DEPTH-1])
out_ack  in  1  consumer 4-phase acknowledge; already synchronised to clk
stage_state  out  DEPTH  debug view of C-element vector c[DEPTH-1:0]
xfer_count  out  16  delivered-token counter (see Optional Feature)

Behaviour:
- State: c[i] (1 bit) and d[i] (WIDTH bits) for i = 0..DEPTH-1.
- Reset (rst_n=0, async): all c=0, all d=0, xfer_count=0. Therefore in_ack=0, out_req=0, out_data=0, stage_state=0 immediately, without waiting for a clock edge.
- Stage inputs:
  - a_i = in_req for i=0, else c[i-1]
  - b_i = ~out_ack for i=DEPTH-1, else ~c[i+1]
- Update rule per edge: if a_i==b_i then c[i] <= a_i, else c[i] holds (C-element).
- All stages evaluate simultaneously from pre-edge values. There is no combinational ripple; a transition advances exactly one stage per cycle.
- Data capture: on the edge where c[i] goes 0->1, d[i] <= in_data (i=0) or d[i-1] (i>0). Otherwise d[i] holds, including on 1->0 transitions.
- Latency, empty pipeline: if in_req=1 is sampled at edge k, then in_ack=1 after edge k, and out_req=1 after edge k+DEPTH-1, i.e. DEPTH edges of propagation including the first.
- Handshake (4-phase, both sides):
  - req rises -> ack rises -> req falls -> ack falls.
  - in_data is captured on the same edge that raises in_ack.
  - out_data is valid whenever out_req=1 and stays stable until out_req falls.
- Full: with out_ack held 0, tokens accumulate in alternating stages. After ceil(DEPTH/2) accepted tokens, c[0] stays 0 while in_req=1, so in_ack stays low (stall). No token is lost or duplicated.
- Empty: all c=0; out_req=0; out_data keeps the last delivered value.
- Protocol violations by the environment (e.g. req dropped before ack) are not detected. The C-element rule simply holds state; no error flag exists.
- Reset mid-operation: all in-flight tokens are discarded. The environment must return in_req/out_ack to 0 before reuse.
- DEPTH<2 or WIDTH<1 is an elaboration error.

Optional Feature:
- Macro: CGATE_MICROPIPELINE_COUNT_EN
- Defined: xfer_count increments by 1 on every edge where c[DEPTH-1] goes 0->1. It wraps from 16'hFFFF to 0 and is cleared by rst_n.
- Undefined: xfer_count is tied to 16'h0000 and no counter flops are generated.
- The port exists in both builds.

Test Plan:
- Reset: assert rst_n=0 mid-transfer with in_req=1 -> in_ack, out_req, stage_state, out_data, xfer_count all 0 before the next clk edge.
- Single token (DEPTH=4, WIDTH=8): in_req=1 with in_data=8'hA5 at edge 0 -> in_ack=1 after edge 0; stage_state walks 0001, 0011, 0111, 1111; out_req=1 after edge 3 with out_data=8'hA5.
- Back-pressure: out_ack held 0; push 8'h11, 8'h22, then 8'h33 -> first two accepted; in_ack stays 0 for 8'h33 for 20 cycles; stage_state settles at 1010 with 1 and 0 as the only transient values.
- Drain in order: from the previous state, run the consumer 4-phase handshake -> outputs 8'h11, 8'h22, 8'h33 in order, no duplicates; stage_state returns to 0000.
- Streaming: producer and consumer respond with zero idle cycles, 100 random bytes -> all received in order; with CGATE_MICROPIPELINE_COUNT_EN, xfer_count=100.
- Counter build off / wrap: macro undefined -> xfer_count=0 throughout; macro defined and 65537 tokens -> xfer_count=1.

Source files
------------

// File: rtl/cgate_micropipeline.sv
// cgate_micropipeline: clocked Muller C-element micropipeline acting as a 4-phase bundled-data FIFO.
// Define CGATE_MICROPIPELINE_COUNT_EN to build the delivered-token counter behind xfer_count.
module cgate_micropipeline #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_req,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ack,
  output logic             out_req,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ack,
  output logic [DEPTH-1:0] stage_state,
  output logic [15:0]      xfer_count
);
  logic [DEPTH-1:0] c;
  logic [DEPTH-1:0] a;
  logic [DEPTH-1:0] b;
  logic [DEPTH-1:0] c_nxt;
  logic [DEPTH-1:0] fire;
  logic [WIDTH-1:0] d   [DEPTH];
  logic [WIDTH-1:0] src [DEPTH];

  if (DEPTH < 2) begin : g_bad_depth
    $error("cgate_micropipeline: DEPTH must be at least 2");
  end
  if (WIDTH < 1) begin : g_bad_width
    $error("cgate_micropipeline: WIDTH must be at least 1");
  end

  // C-element inputs: forward request from the left, inverted state from the right.
  // next = majority(a, b, c): follows a when a==b, holds otherwise.
  // fire marks a 0->1 transition, the only moment a stage latches data.
  always_comb begin
    a     = {c[DEPTH-2:0], in_req};
    b     = {~out_ack, ~c[DEPTH-1:1]};
    c_nxt = (a & b) | (c & (a | b));
    fire  = ~c & a & b;
  end

  // Data source for each stage: producer bus for the first, previous latch otherwise.
  always_comb begin
    src[0] = in_data;
    for (int i = 1; i < DEPTH; i++) src[i] = d[i-1];
  end

  // Control state: all stages step together from their pre-edge neighbours.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) c <= '0;
    else c <= c_nxt;
  end

  // Data latches: capture on the rising control transition, hold on everything else.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) for (int i = 0; i < DEPTH; i++) d[i] <= '0;
    else for (int i = 0; i < DEPTH; i++) d[i] <= fire[i] ? src[i] : d[i];
  end

  assign in_ack      = c[0];
  assign out_req     = c[DEPTH-1];
  assign out_data    = d[DEPTH-1];
  assign stage_state = c;

`ifdef CGATE_MICROPIPELINE_COUNT_EN
  logic [15:0] cnt;

  // Count each token presented to the consumer; wraps naturally at 16 bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt <= '0;
    else if (fire[DEPTH-1]) cnt <= cnt + 16'd1;
  end

  assign xfer_count = cnt;
`else
  assign xfer_count = 16'h0000;
`endif
endmodule

// File: tb/tb_cgate_micropipeline.sv
// tb_cgate_micropipeline: scoreboard bench for the C-element micropipeline (DEPTH=4, WIDTH=8).
module tb_cgate_micropipeline;
  localparam int W = 8;
  localparam int D = 4;
`ifdef CGATE_MICROPIPELINE_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic         clk;
  logic         rst_n;
  logic         in_req;
  logic [W-1:0] in_data;
  logic         in_ack;
  logic         out_req;
  logic [W-1:0] out_data;
  logic         out_ack;
  logic [D-1:0] stage_state;
  logic [15:0]  xfer_count;

  int vectors = 0;
  int miscompares = 0;
  int delivered = 0;
  logic [W-1:0] sb [$];

  cgate_micropipeline #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_req(in_req),
    .in_data(in_data),
    .in_ack(in_ack),
    .out_req(out_req),
    .out_data(out_data),
    .out_ack(out_ack),
    .stage_state(stage_state),
    .xfer_count(xfer_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] want_count();
    return CNT_EN ? delivered[15:0] : 16'h0000;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    in_req = 1'b0;
    out_ack = 1'b0;
    sb.delete();
    delivered = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic produce(input logic [W-1:0] v);
    int n = 0;
    in_data = v;
    in_req = 1'b1;
    do begin @(negedge clk); n++; end while (in_ack !== 1'b1 && n < 50);
    vectors++;
    if (in_ack !== 1'b1) begin
      miscompares++;
      $display("FAIL produce_ack_rise: in_ack=%b want 1 (data %h)", in_ack, v);
    end else sb.push_back(v);
    in_req = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (in_ack !== 1'b0 && n < 50);
    vectors++;
    if (in_ack !== 1'b0) begin
      miscompares++;
      $display("FAIL produce_ack_fall: in_ack=%b want 0 (data %h)", in_ack, v);
    end
  endtask

  task automatic consume(input int num, input int budget);
    int got = 0;
    int cyc = 0;
    logic [W-1:0] want;
    while ((got < num || out_ack) && cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (!out_ack && out_req) begin
        vectors++;
        if (sb.size() == 0) begin
          miscompares++;
          $display("FAIL consume_extra: out_data=%h but no token outstanding", out_data);
        end else begin
          want = sb.pop_front();
          if (out_data !== want) begin
            miscompares++;
            $display("FAIL consume_data: out_data=%h want %h", out_data, want);
          end
        end
        delivered++;
        got++;
        out_ack = 1'b1;
      end else if (out_ack && !out_req) out_ack = 1'b0;
    end
    vectors++;
    if (got < num || out_ack) begin
      miscompares++;
      $display("FAIL consume_timeout: got %0d tokens want %0d", got, num);
    end
  endtask

  task automatic wait_empty(input string tag);
    int n = 0;
    while (stage_state !== '0 && n < 50) begin @(negedge clk); n++; end
    vectors++;
    if (stage_state !== '0) begin
      miscompares++;
      $display("FAIL %s_empty: stage_state=%b want 0000", tag, stage_state);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_req = 1'b0;
    out_ack = 1'b0;
    in_data = '0;
    repeat (2) @(negedge clk);
    vectors += 5;
    if (stage_state !== '0) begin miscompares++; $display("FAIL reset_state: stage_state=%b want 0000", stage_state); end
    if (in_ack !== 1'b0) begin miscompares++; $display("FAIL reset_in_ack: in_ack=%b want 0", in_ack); end
    if (out_req !== 1'b0) begin miscompares++; $display("FAIL reset_out_req: out_req=%b want 0", out_req); end
    if (out_data !== '0) begin miscompares++; $display("FAIL reset_out_data: out_data=%h want 00", out_data); end
    if (xfer_count !== 16'h0) begin miscompares++; $display("FAIL reset_count: xfer_count=%h want 0000", xfer_count); end
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    logic [D-1:0] walk [D];
    walk = '{4'b0001, 4'b0011, 4'b0111, 4'b1111};
    @(negedge clk);
    in_data = 8'hA5;
    in_req = 1'b1;
    sb.push_back(8'hA5);
    for (int i = 0; i < D; i++) begin
      @(negedge clk);
      vectors += 3;
      if (stage_state !== walk[i]) begin miscompares++; $display("FAIL single_walk%0d: stage_state=%b want %b", i, stage_state, walk[i]); end
      if (in_ack !== 1'b1) begin miscompares++; $display("FAIL single_in_ack%0d: in_ack=%b want 1", i, in_ack); end
      if (out_req !== (i == D - 1)) begin miscompares++; $display("FAIL single_out_req%0d: out_req=%b want %b", i, out_req, i == D - 1); end
    end
    vectors++;
    if (out_data !== 8'hA5) begin miscompares++; $display("FAIL single_out_data: out_data=%h want a5", out_data); end
    in_req = 1'b0;
    consume(1, 50);
    wait_empty("single");
    vectors++;
    if (xfer_count !== want_count()) begin miscompares++; $display("FAIL single_count: xfer_count=%h want %h", xfer_count, want_count()); end
  endtask

  task automatic test_backpressure();
    out_ack = 1'b0;
    produce(8'h11);
    produce(8'h22);
    in_data = 8'h33;
    in_req = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      vectors++;
      if (in_ack !== 1'b0) begin miscompares++; $display("FAIL bp_stall%0d: in_ack=%b want 0", i, in_ack); end
    end
    vectors += 3;
    if (stage_state !== 4'b1010) begin miscompares++; $display("FAIL bp_state: stage_state=%b want 1010", stage_state); end
    if (out_req !== 1'b1) begin miscompares++; $display("FAIL bp_out_req: out_req=%b want 1", out_req); end
    if (out_data !== 8'h11) begin miscompares++; $display("FAIL bp_out_data: out_data=%h want 11", out_data); end
  endtask

  task automatic test_drain();
    fork
      begin
        int n = 0;
        while (in_ack !== 1'b1 && n < 200) begin @(negedge clk); n++; end
        vectors++;
        if (in_ack !== 1'b1) begin
          miscompares++;
          $display("FAIL drain_accept: in_ack=%b want 1 for data 33", in_ack);
        end else sb.push_back(8'h33);
        in_req = 1'b0;
      end
      consume(3, 300);
    join
    wait_empty("drain");
    vectors += 2;
    if (sb.size() != 0) begin miscompares++; $display("FAIL drain_leftover: %0d tokens undelivered want 0", sb.size()); end
    if (out_data !== 8'h33) begin miscompares++; $display("FAIL drain_last: out_data=%h want 33", out_data); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    in_data = 8'h5A;
    in_req = 1'b1;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    vectors += 5;
    if (stage_state !== '0) begin miscompares++; $display("FAIL midrst_state: stage_state=%b want 0000", stage_state); end
    if (in_ack !== 1'b0) begin miscompares++; $display("FAIL midrst_in_ack: in_ack=%b want 0", in_ack); end
    if (out_req !== 1'b0) begin miscompares++; $display("FAIL midrst_out_req: out_req=%b want 0", out_req); end
    if (out_data !== '0) begin miscompares++; $display("FAIL midrst_out_data: out_data=%h want 00", out_data); end
    if (xfer_count !== 16'h0) begin miscompares++; $display("FAIL midrst_count: xfer_count=%h want 0000", xfer_count); end
    in_req = 1'b0;
    sb.delete();
    delivered = 0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_stream();
    do_reset();
    fork
      for (int i = 0; i < 100; i++) produce(W'($urandom_range(0, 255)));
      consume(100, 5000);
    join
    wait_empty("stream");
    vectors += 2;
    if (sb.size() != 0) begin miscompares++; $display("FAIL stream_leftover: %0d tokens undelivered want 0", sb.size()); end
    if (xfer_count !== want_count()) begin miscompares++; $display("FAIL stream_count: xfer_count=%h want %h", xfer_count, want_count()); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_drain();
    test_reset_mid();
    test_stream();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
